// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and the dcache.
// The dcache has priority. A grant is held until the RAM completes
// (ramwait low) or the granted requester withdraws.
//
// Optional build macro ARB_FAIRNESS_EN: after STARVE_MAX consecutive dcache
// grants made while iREN is pending, the icache is forced in.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   iREN, iaddr           icache read request and word address
//   iload, iwait          icache read data (passthrough) and stall
//   dREN, dWEN            dcache read / write requests
//   daddr, dstore         dcache address and write data
//   dload, dwait          dcache read data (passthrough) and stall
//   ramREN, ramWEN        RAM read / write enables
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramwait      RAM read data and busy flag
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramwait
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   force_i;

  // Read data goes straight to both caches; only the granted one samples it.
  assign iload = ramload;
  assign dload = ramload;

`ifdef ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  assign force_i = (starve_cnt == CNT_W'(STARVE_MAX)) & iREN;

  // Count dcache wins taken while the icache is waiting.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (state == IDLE) begin
      if ((state_nxt == DGNT) && iREN) begin
        starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end else if ((state_nxt == IGNT) || !iREN) begin
        starve_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end
`else
  assign force_i = 1'b0;

  // Parameter is only meaningful with the fairness counter built in.
  wire unused_starve_max = (STARVE_MAX == 0);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and RAM/stall outputs; enables are gated by the live request
  // so a withdrawal drops them in the same cycle.
  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = 32'd0;
    ramstore  = 32'd0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    case (state)
      IDLE: begin
        if ((dREN | dWEN) & !force_i) begin
          state_nxt = DGNT;
        end else if (iREN) begin
          state_nxt = IGNT;
        end
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ramwait;
        if (!ramwait || !iREN) begin
          state_nxt = IDLE;
        end
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        if (dWEN) begin
          ramWEN = 1'b1;
        end else begin
          ramREN = dREN;
        end
        dwait = ramwait;
        if (!ramwait || !(dREN | dWEN)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized, protocol-following requesters, all compared against a
// port-ownership model evaluated every cycle.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, ramwait;
  logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int    errors = 0;
  int    checks = 0;

  // Model: who owns the RAM port (0 nobody, 1 icache, 2 dcache) and how many
  // dcache wins have gone by while the icache waited.
  int    owner  = 0;
  int    starve = 0;
  bit    i_done = 1'b0;
  bit    d_done = 1'b0;
  string gnt_log = "";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check at the falling edge, then advance the
  // model by one rising edge.
  task automatic step();
    logic        e_ren, e_wen, e_iw, e_dw, want_d, frc;
    logic [31:0] e_addr, e_store;
    int          nxt;
    #4;
    e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
    e_addr = 32'd0; e_store = 32'd0;
    if (owner == 1) begin
      e_addr = iaddr;
      e_ren  = iREN;
      e_iw   = ramwait;
    end else if (owner == 2) begin
      e_addr  = daddr;
      e_store = dstore;
      e_wen   = dWEN;
      e_ren   = dREN & !dWEN;
      e_dw    = ramwait;
    end
    check("ramREN",   32'(ramREN),   32'(e_ren));
    check("ramWEN",   32'(ramWEN),   32'(e_wen));
    check("ramaddr",  ramaddr,       e_addr);
    check("ramstore", ramstore,      e_store);
    check("iwait",    32'(iwait),    32'(e_iw));
    check("dwait",    32'(dwait),    32'(e_dw));
    check("iload",    iload,         ramload);
    check("dload",    dload,         ramload);

    if (dwait === 1'b0)      gnt_log = {gnt_log, "D"};
    else if (iwait === 1'b0) gnt_log = {gnt_log, "I"};

    i_done = (owner == 1) && !ramwait;
    d_done = (owner == 2) && !ramwait;
    want_d = dREN | dWEN;
`ifdef ARB_FAIRNESS_EN
    frc = (starve == STARVE_MAX) && iREN;
`else
    frc = 1'b0;
`endif
    nxt = owner;
    if (owner == 0) begin
      if (want_d && !frc) nxt = 2;
      else if (iREN)      nxt = 1;
      if (nxt == 2 && iREN)          starve = starve + 1;
      else if (nxt == 1 || !iREN)    starve = 0;
    end else if (owner == 1) begin
      if (!ramwait || !iREN) nxt = 0;
    end else begin
      if (!ramwait || !want_d) nxt = 0;
    end
    if (RST) begin
      nxt    = 0;
      starve = 0;
    end
    owner = nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramwait = 1'b1;
  endtask

  string exp_gnt;
  bit    i_act, d_act;
  int    op;
  logic [7:0] ch;

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
    ramwait = 1'b1; ramload = 32'hA5A5_0001;
    @(posedge CLK);
    #1;
    owner = 0; starve = 0;
    step();                       // reset state, RST still high
    RST = 1'b0;

    // Single icache read, completes on the 2nd grant cycle.
    iREN = 1'b1; iaddr = 32'h40; step();
    step();
    ramwait = 1'b0; ramload = 32'hDEAD_BEEF; step();
    iREN = 1'b0; ramwait = 1'b1; step();

    // Simultaneous icache read and dcache write: dcache first.
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
    ramwait = 1'b0; step();
    step();
    dWEN = 1'b0; step();
    step();
    iREN = 1'b0; step();

    // Write wins over read in the same request.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h5678; step();
    step();
    idle_inputs(); step();

    // Icache withdraws mid-grant.
    iREN = 1'b1; iaddr = 32'h80; ramwait = 1'b1; step();
    step();
    iREN = 1'b0; step();
    step();

    // Reset in the middle of a dcache grant.
    dREN = 1'b1; daddr = 32'h300; step();
    step();
    RST = 1'b1; step();
    RST = 1'b0; dREN = 1'b0; step();

    // Both requesters held continuously: grant order.
    RST = 1'b1; step();
    RST = 1'b0;
    gnt_log = "";
    iREN = 1'b1; iaddr = 32'h1000; dREN = 1'b1; daddr = 32'h2000; ramwait = 1'b0;
    for (int k = 0; k < 12; k++) step();
`ifdef ARB_FAIRNESS_EN
    exp_gnt = "DDDDID";
`else
    exp_gnt = "DDDDDD";
`endif
    for (int k = 0; k < 6; k++) begin
      ch = (k < gnt_log.len()) ? gnt_log[k] : 8'h2D;
      check("grant_order", 32'(ch), 32'(exp_gnt[k]));
    end
    idle_inputs(); RST = 1'b1; step();
    RST = 1'b0;

    // Randomized traffic with protocol-following requesters.
    i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 99) == 0);
      if (i_act) begin
        if (i_done || $urandom_range(0, 49) == 0) begin
          iREN = 1'b0; i_act = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        iREN = 1'b1; iaddr = $urandom; i_act = 1'b1;
      end
      if (d_act) begin
        if (d_done || $urandom_range(0, 49) == 0) begin
          dREN = 1'b0; dWEN = 1'b0; d_act = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        op = int'($urandom_range(0, 2));
        dREN = (op != 1); dWEN = (op != 0);
        daddr = $urandom; dstore = $urandom; d_act = 1'b1;
      end
      ramwait = ($urandom_range(0, 2) != 0);
      ramload = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares the single RAM port between the instruction cache and the data cache. It sits between the caches' memory-side signals (iREN/iaddr/iload/iwait, dREN/dWEN/daddr/dstore/dload/dwait) and the RAM. It grants one requester at a time, holds the grant until the RAM completes, and gives data-side priority with optional icache starvation protection.

## Interface
- STARVE_MAX, 4: consecutive dcache grants allowed while iREN is pending before icache is forced (only used with ARB_FAIRNESS_EN).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iload  out  32  read data to icache.
- iwait  out  1  icache stall; low only in the icache completion cycle.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dload  out  32  read data to dcache.
- dwait  out  1  dcache stall; low only in the dcache completion cycle.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramwait  in  1  RAM busy; low means the access completes this cycle.

## Operation
- States: IDLE, IGNT, DGNT (2-bit register).
- IDLE: drives no RAM access. Arbitrates on registered-state entry conditions:
  - (dREN|dWEN) & !force_i -> DGNT.
  - Otherwise iREN -> IGNT.
  - Otherwise stay IDLE.
- DGNT: ramaddr=daddr, ramstore=dstore.
  - dWEN high: ramWEN=1, ramREN=0 (dWEN wins over simultaneous dREN).
  - Else: ramREN=dREN.
  - dwait = ramwait.
  - Next state IDLE when ramwait=0, or when dREN|dWEN drops.
- IGNT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0, iwait=ramwait. Next state IDLE when ramwait=0 or iREN drops.
- Non-granted requester's wait is held at 1. Both waits are 1 in IDLE.
- iload = ramload and dload = ramload at all times (pure combinational passthrough, unregistered).
- force_i = 0 without ARB_FAIRNESS_EN.

## Timing
- Reset (RST=1 at an edge) gives, from the next cycle:
  - state IDLE, starvation counter 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
  - iload/dload follow ramload.
- Reset mid-transaction aborts it. The RAM enables drop the cycle after RST is sampled. The requester sees no completion and must re-request.
- Request first seen in IDLE at cycle N -> grant state and RAM enables asserted in N+1. The requester's wait is low in the first grant cycle where ramwait=0 (earliest N+1). The FSM is back in IDLE the cycle after completion.
- Minimum 2 cycles per access. Back-to-back accesses have one IDLE bubble.
- Requesters hold request, address and data stable until their wait is low, and drop the request in the cycle after completion.
- Withdrawal: a requester that drops its request while granted causes the RAM enables to drop in the same cycle (gated), with return to IDLE next cycle.
- Simultaneous iREN and dREN/dWEN in IDLE: dcache wins, unless force_i is set.

## Configuration
- ARB_FAIRNESS_EN defined: adds a counter of width clog2(STARVE_MAX+1).
  - Increments on each IDLE->DGNT decision made while iREN=1.
  - Clears on IDLE->IGNT, on any IDLE cycle with iREN=0, and on reset.
  - force_i = (count == STARVE_MAX) & iREN.
- ARB_FAIRNESS_EN undefined: no counter; strict dcache priority, so the icache can starve indefinitely.

## Test plan
- Single icache read, iaddr=0x40, ramwait low on the 2nd grant cycle, ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x40 for 2 cycles. iwait low with iload=0xDEADBEEF in exactly that cycle; IDLE next cycle.
- Conflict: iREN and dWEN raised together, daddr=0x100, dstore=0x1234 -> DGNT first (ramWEN=1, ramstore=0x1234). After dcache completion, one IDLE cycle, then IGNT.
- Write precedence: dREN=dWEN=1 -> ramWEN=1, ramREN=0.
- Withdrawal: iREN dropped mid-IGNT while ramwait=1 -> ramREN=0 that cycle, IDLE next cycle, iwait never low.
- Reset mid-DGNT with ramwait=1 -> next cycle: IDLE, all RAM enables 0, iwait=dwait=1.
- ARB_FAIRNESS_EN, STARVE_MAX=4, dREN held continuously with iREN=1 -> grants in order D,D,D,D,I,D... Without the macro, every grant is D.
